// File: rtl/fifo_feeder_pkg.sv
// Shared encodings and defaults for the FIFO-to-UART-TX feeder.
// State codes are fixed 3-bit values so they stay stable across builds.
package fifo_feeder_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_POP     = 3'd1;
  localparam logic [2:0] ENC_SEND    = 3'd2;
  localparam logic [2:0] ENC_WAIT_HI = 3'd3;
  localparam logic [2:0] ENC_WAIT_LO = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ENC_IDLE,
    POP     = ENC_POP,
    SEND    = ENC_SEND,
    WAIT_HI = ENC_WAIT_HI,
    WAIT_LO = ENC_WAIT_LO
  } feeder_state_t;

endpackage

// File: rtl/feeder_timeout_cnt.sv
// 8-bit clear/enable counter; tc flags the enabled cycle whose increment reaches terminal.
// Zero latency on tc, no backpressure.
module feeder_timeout_cnt #(
  parameter int TC_VAL = 14
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_CNT = 8'(TC_VAL);

  logic [7:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = en && (cnt == TC_CNT);

endmodule

// File: rtl/fifo_tx_feeder.sv
// Drains the read side of the async FIFO into UART TX, one word per BUSY handshake; 4 cycles overhead per word.
// Waits on FIFO_EMPTY/TX_BUSY in IDLE; optional BUSY-rise timeout with sticky TX_ERR under FEEDER_TIMEOUT_EN.
module fifo_tx_feeder
  import fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef FEEDER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_R_INC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  FEED_ACTIVE
`ifdef FEEDER_TIMEOUT_EN
  , output logic                TX_ERR
`endif
);

  feeder_state_t state, state_nxt;
  logic          timeout;

`ifdef FEEDER_TIMEOUT_EN
  // tc fires on the WAIT_HI cycle whose increment reaches TIMEOUT_CYC-1,
  // so IDLE is re-entered TIMEOUT_CYC cycles after SEND.
  feeder_timeout_cnt #(
    .TC_VAL (TIMEOUT_CYC - 2)
  ) u_timeout_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (state == SEND),
    .en  (state == WAIT_HI),
    .tc  (timeout)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_ERR <= 1'b0;
    end else if (state == WAIT_HI && !TX_BUSY && timeout) begin
      TX_ERR <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN && !FIFO_EMPTY && !TX_BUSY) state_nxt = POP;
      POP:     state_nxt = SEND;
      SEND:    state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (TX_BUSY) begin
          state_nxt = WAIT_LO;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      WAIT_LO: if (!TX_BUSY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on the pop edge; the word stays put until the next pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_P_DATA <= '0;
    end else if (state == POP) begin
      TX_P_DATA <= FIFO_RD_DATA;
    end
  end

  assign FIFO_R_INC  = (state == POP);
  assign TX_D_VLD    = (state == SEND);
  assign FEED_ACTIVE = (state != IDLE);

endmodule

// File: doc/fifo_tx_feeder.md
# fifo_tx_feeder

Read-side controller that drains the asynchronous FIFO into the UART transmitter. It lives in the FIFO read/UART TX clock domain. It pops one word at a time when the FIFO is non-empty and the transmitter is idle, and hands the word to the transmitter with a single-cycle valid pulse. It then tracks the transmitter's BUSY handshake until the frame completes.

## Interface
- DATA_WIDTH, 8, width of FIFO words and of the UART TX parallel data
- TIMEOUT_CYC, 16, cycles to wait for TX_BUSY to rise after TX_D_VLD; used only with FEEDER_TIMEOUT_EN; legal range 2..255

- CLK  in  1  read/TX domain clock; one clock only
- RST  in  1  asynchronous, active-low reset
- EN  in  1  drain enable, level; sampled only in IDLE
- FIFO_EMPTY  in  1  FIFO empty flag, read domain
- FIFO_RD_DATA  in  DATA_WIDTH  FIFO word at the current read address; valid whenever FIFO_EMPTY=0
- FIFO_R_INC  out  1  pop strobe, one cycle per word
- TX_BUSY  in  1  UART TX busy
- TX_P_DATA  out  DATA_WIDTH  registered word presented to UART TX
- TX_D_VLD  out  1  single-cycle data-valid pulse to UART TX
- FEED_ACTIVE  out  1  high in every state except IDLE
- TX_ERR  out  1  sticky BUSY-timeout flag; port exists only with FEEDER_TIMEOUT_EN

## Operation
- Moore FSM with five states: IDLE, POP, SEND, WAIT_HI, WAIT_LO. FIFO_R_INC, TX_D_VLD and FEED_ACTIVE decode from the state register only.
- IDLE: if EN=1, FIFO_EMPTY=0 and TX_BUSY=0, go to POP. Otherwise stay.
- POP: FIFO_R_INC=1. On this edge TX_P_DATA <= FIFO_RD_DATA. Go to SEND.
- SEND: TX_D_VLD=1. Go to WAIT_HI.
- WAIT_HI: wait for TX_BUSY=1, then go to WAIT_LO.
- WAIT_LO: wait for TX_BUSY=0, then go to IDLE.
- FIFO_EMPTY is not re-checked after IDLE. Only this block pops, so a non-empty FIFO cannot become empty before the pop.
- Pops are at least 5 cycles apart. This covers the one-cycle lag of the registered gray read pointer feeding FIFO_EMPTY.
- EN deasserted mid-word: the current word completes through WAIT_LO, then the FSM parks in IDLE. No further pops.
- TX_P_DATA holds its value until the next POP.

## Timing
- Reset values: state=IDLE, FIFO_R_INC=0, TX_D_VLD=0, TX_P_DATA=0, FEED_ACTIVE=0, TX_ERR=0.
- Reset asserted mid-operation immediately returns all outputs to their reset values. A word already popped but not yet sent is lost, by design.
- Cycle t: IDLE with the start condition true. Cycle t+1: POP. Cycle t+2: SEND, with TX_P_DATA valid. TX_P_DATA is stable from t+2 through the next POP.
- Total overhead is 4 cycles per word beyond the TX frame.
- TX_BUSY already high at the start condition blocks the start. It does not count as a handshake.

## Configuration
- FEEDER_TIMEOUT_EN defined:
  - an 8-bit counter clears on SEND and increments each WAIT_HI cycle;
  - if TX_BUSY is still 0 when the count reaches TIMEOUT_CYC-1, the FSM goes to IDLE and TX_ERR is set;
  - the word is dropped;
  - TX_ERR clears only on reset.
- FEEDER_TIMEOUT_EN undefined: WAIT_HI waits indefinitely. There is no counter and no TX_ERR port.

## Structure
- Shared package fifo_feeder_pkg holds:
  - state encodings as localparams: IDLE=0, POP=1, SEND=2, WAIT_HI=3, WAIT_LO=4, 3-bit;
  - default DATA_WIDTH and TIMEOUT_CYC constants.
- One natural sub-module, feeder_timeout_cnt: clear/enable/terminal-count counter, instantiated only under FEEDER_TIMEOUT_EN. Everything else stays in the top module.

## Test plan
- Reset mid-WAIT_LO: FIFO_R_INC, TX_D_VLD, TX_P_DATA=0 and FEED_ACTIVE=0 immediately. FSM is in IDLE after release.
- FIFO preloaded with 0xA5, EN=1, TX model raises BUSY 1 cycle after valid for 10 cycles:
  - exactly one FIFO_R_INC;
  - TX_P_DATA=0xA5 when TX_D_VLD=1, 2 cycles after start;
  - return to IDLE after BUSY falls.
- FIFO preloaded with 0x01..0x04: four pops in order; TX_D_VLD never asserted while TX_BUSY=1; pops spaced at least 5 cycles apart; FIFO_R_INC stops once FIFO_EMPTY=1.
- EN dropped during WAIT_HI with 3 words queued: current word completes, no further FIFO_R_INC, 2 words remain. Re-assert EN: both drain.
- TX_BUSY held 1 before start with FIFO non-empty: no pop until BUSY falls, then the normal sequence.
- FEEDER_TIMEOUT_EN, TIMEOUT_CYC=16, TX_BUSY tied 0: one pop, return to IDLE 16 cycles after SEND, TX_ERR=1 and held until reset, next word then popped.
